// File: rtl/four_12_12_err_arb.sv
// rtl/four_12_12_err_arb.sv - frame-atomic round-robin arbiter for a shared error datapath
module four_12_12_err_arb #(
   parameter int FRAME_LEN = 120,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] req0_data,
   input  logic        req0_fst,
   input  logic        req0_vld,
   output logic        req0_rdy,
   input  logic [31:0] req1_data,
   input  logic        req1_fst,
   input  logic        req1_vld,
   output logic        req1_rdy,
   output logic [31:0] dp_data,
   output logic        dp_fst,
   output logic        dp_vld,
   input  logic        dp_rdy,
   input  logic [31:0] dp_res_data,
   output logic [31:0] err0_data,
   output logic        err0_vld,
   output logic        err0_done,
   output logic [31:0] err1_data,
   output logic        err1_vld,
   output logic        err1_done,
   output logic        sync_err
);

   localparam int CW = 7;

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_q, state_d;
   logic          prio_q, prio_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync_err_q, sync_err_d;

   logic [LATENCY-1:0] pipe_acc_q;
   logic [LATENCY-1:0] pipe_own_q;
   logic [LATENCY-1:0] pipe_last_q;

   logic cand0, cand1, win;
   logic fwd_sel, drop_any, fst_err;
   logic acc, acc_last;

   // Only beats that open a frame may compete; a tie goes to the priority holder.
   assign cand0 = req0_vld & req0_fst;
   assign cand1 = req1_vld & req1_fst;
   assign win   = cand1 & (~cand0 | prio_q);

   assign acc      = dp_vld & dp_rdy;
   assign acc_last = acc & (state_q == BURST) & (cnt_q == CW'(FRAME_LEN - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         sync_err_q  <= 1'b0;
         pipe_acc_q  <= '0;
         pipe_own_q  <= '0;
         pipe_last_q <= '0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         sync_err_q    <= sync_err_d;
         pipe_acc_q[0] <= acc;
         pipe_own_q[0] <= fwd_sel;
         pipe_last_q[0] <= acc_last;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_acc_q[i]  <= pipe_acc_q[i-1];
            pipe_own_q[i]  <= pipe_own_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      sync_err_d = sync_err_q | drop_any | fst_err;
      if (acc) begin
         if (state_q == IDLE) begin
            owner_d = fwd_sel;
            cnt_d   = CW'(1);
            state_d = BURST;
         end else if (acc_last) begin
            cnt_d   = '0;
            state_d = IDLE;
            prio_d  = ~owner_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      req0_rdy = 1'b0;
      req1_rdy = 1'b0;
      dp_vld   = 1'b0;
      dp_fst   = 1'b0;
      dp_data  = '0;
      fwd_sel  = 1'b0;
      drop_any = 1'b0;
      fst_err  = 1'b0;
      if (reset) begin
         case (state_q)
            IDLE: begin
               if (cand0 | cand1) begin
                  fwd_sel = win;
                  dp_vld  = 1'b1;
                  dp_fst  = 1'b1;
                  dp_data = win ? req1_data : req0_data;
                  if (win) req1_rdy = dp_rdy;
                  else     req0_rdy = dp_rdy;
               end
               // Stray mid-frame beats are swallowed so the sender cannot stall.
               if (req0_vld & ~req0_fst) begin
                  req0_rdy = 1'b1;
                  drop_any = 1'b1;
               end
               if (req1_vld & ~req1_fst) begin
                  req1_rdy = 1'b1;
                  drop_any = 1'b1;
               end
            end
            default: begin
               fwd_sel = owner_q;
               dp_vld  = owner_q ? req1_vld : req0_vld;
               dp_data = dp_vld ? (owner_q ? req1_data : req0_data) : '0;
               fst_err = dp_vld & dp_rdy & (owner_q ? req1_fst : req0_fst);
               if (owner_q) req1_rdy = dp_rdy;
               else         req0_rdy = dp_rdy;
            end
         endcase
      end
   end

   assign err0_vld  = pipe_acc_q[LATENCY-1] & ~pipe_own_q[LATENCY-1];
   assign err1_vld  = pipe_acc_q[LATENCY-1] &  pipe_own_q[LATENCY-1];
   assign err0_done = err0_vld & pipe_last_q[LATENCY-1];
   assign err1_done = err1_vld & pipe_last_q[LATENCY-1];
   assign err0_data = err0_vld ? dp_res_data : '0;
   assign err1_data = err1_vld ? dp_res_data : '0;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_four_12_12_err_arb.sv
// tb/tb_four_12_12_err_arb.sv - directed self-checking bench for four_12_12_err_arb
module tb_four_12_12_err_arb;

   localparam int FL  = 120;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] req0_data, req1_data;
   logic        req0_fst, req0_vld, req0_rdy;
   logic        req1_fst, req1_vld, req1_rdy;
   logic [31:0] dp_data;
   logic        dp_fst, dp_vld, dp_rdy;
   logic [31:0] dp_res_data;
   logic [31:0] err0_data, err1_data;
   logic        err0_vld, err0_done, err1_vld, err1_done;
   logic        sync_err;

   int errors = 0;
   int checks = 0;

   logic ep_acc  [LAT];
   logic ep_own  [LAT];
   logic ep_last [LAT];

   four_12_12_err_arb #(.FRAME_LEN(FL), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_data(req0_data), .req0_fst(req0_fst), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
      .req1_data(req1_data), .req1_fst(req1_fst), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
      .dp_data(dp_data), .dp_fst(dp_fst), .dp_vld(dp_vld), .dp_rdy(dp_rdy),
      .dp_res_data(dp_res_data),
      .err0_data(err0_data), .err0_vld(err0_vld), .err0_done(err0_done),
      .err1_data(err1_data), .err1_vld(err1_vld), .err1_done(err1_done),
      .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] da(input int i);
      return 32'h0A00_0000 | 32'(i);
   endfunction

   function automatic logic [31:0] db(input int i);
      return 32'h1B00_0000 | 32'(i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < LAT; i++) begin
         ep_acc[i]  = 1'b0;
         ep_own[i]  = 1'b0;
         ep_last[i] = 1'b0;
      end
   endtask

   task automatic drive(input logic v0, input logic f0, input logic [31:0] d0,
                        input logic v1, input logic f1, input logic [31:0] d1,
                        input logic rdy);
      req0_vld = v0; req0_fst = f0; req0_data = d0;
      req1_vld = v1; req1_fst = f1; req1_data = d1;
      dp_rdy   = rdy;
   endtask

   // fwd: requester expected on dp (-1 none); called at posedge+1, returns at posedge+1.
   task automatic step(input int fwd, input logic e0, input logic e1,
                       input logic efst, input logic elast);
      logic        acc, v0, v1;
      logic [31:0] ed;
      @(negedge clk);
      ed = (fwd == 0) ? req0_data : (fwd == 1) ? req1_data : 32'h0;
      chk("req0_rdy", req0_rdy, e0);
      chk("req1_rdy", req1_rdy, e1);
      chk("dp_vld", dp_vld, fwd >= 0);
      chk("dp_fst", dp_fst, efst && fwd >= 0);
      chk("dp_data", dp_data, ed);
      v0 = ep_acc[LAT-1] && !ep_own[LAT-1];
      v1 = ep_acc[LAT-1] &&  ep_own[LAT-1];
      chk("err0_vld", err0_vld, v0);
      chk("err1_vld", err1_vld, v1);
      chk("err0_done", err0_done, v0 && ep_last[LAT-1]);
      chk("err1_done", err1_done, v1 && ep_last[LAT-1]);
      chk("err0_data", err0_data, v0 ? dp_res_data : 32'h0);
      chk("err1_data", err1_data, v1 ? dp_res_data : 32'h0);
      acc = (fwd >= 0) && dp_rdy;
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
         ep_acc[i]  = ep_acc[i-1];
         ep_own[i]  = ep_own[i-1];
         ep_last[i] = ep_last[i-1];
      end
      ep_acc[0]   = acc;
      ep_own[0]   = (fwd == 1);
      ep_last[0]  = elast;
      dp_res_data = $urandom;
   endtask

   // Body beats from..to of a frame owned by `who`; the other requester holds ov/of/od.
   task automatic beats(input int who, input int from, input int to, input bit toggle,
                        input logic ov, input logic of, input logic [31:0] od);
      int  b = from;
      bit  t = 1'b0;
      logic rdy;
      while (b <= to) begin
         rdy = toggle ? t : 1'b1;
         if (who == 0) drive(1'b1, 1'b0, da(b), ov, of, od, rdy);
         else          drive(ov, of, od, 1'b1, 1'b0, db(b), rdy);
         step(who, (who == 0) ? rdy : 1'b0, (who == 1) ? rdy : 1'b0, 1'b0,
              rdy && (b == FL - 1));
         if (rdy) b++;
         t = ~t;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
         step(-1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset = 1'b0;
      dp_res_data = 32'h0;
      clear_model();
      drive(1'b1, 1'b1, da(0), 1'b1, 1'b1, db(0), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req0_rdy", req0_rdy, 1'b0);
      chk("rst_req1_rdy", req1_rdy, 1'b0);
      chk("rst_dp_vld", dp_vld, 1'b0);
      chk("rst_dp_fst", dp_fst, 1'b0);
      chk("rst_dp_data", dp_data, 32'h0);
      chk("rst_err0_vld", err0_vld, 1'b0);
      chk("rst_err1_vld", err1_vld, 1'b0);
      chk("rst_sync_err", sync_err, 1'b0);
      reset = 1'b1;

      // Contention after reset: req0 wins, req1 follows with zero gap.
      drive(1'b1, 1'b1, da(0), 1'b1, 1'b1, db(0), 1'b1);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0);
      beats(0, 1, FL - 1, 1'b0, 1'b1, 1'b1, db(0));
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, db(0), 1'b1);
      step(1, 1'b0, 1'b1, 1'b1, 1'b0);
      beats(1, 1, FL - 1, 1'b0, 1'b0, 1'b0, 32'h0);
      // Next contention alternates back to req0; frame body under toggling dp_rdy.
      drive(1'b1, 1'b1, da(0), 1'b1, 1'b1, db(0), 1'b1);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0);
      beats(0, 1, FL - 1, 1'b1, 1'b0, 1'b0, 32'h0);
      idle(4);

      // Single req0 frame back-to-back.
      drive(1'b1, 1'b1, da(0), 1'b0, 1'b0, 32'h0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0);
      beats(0, 1, FL - 1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(4);
      chk("sync_err_clean", sync_err, 1'b0);

      // Stray beat in IDLE is dropped and flagged.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, db(5), 1'b1);
      step(-1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("sync_err_drop", sync_err, 1'b1);
      drive(1'b1, 1'b1, da(0), 1'b1, 1'b0, db(6), 1'b1);
      step(0, 1'b1, 1'b1, 1'b1, 1'b0);
      beats(0, 1, FL - 1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(4);

      reset = 1'b0;
      #1;
      chk("sync_err_rst", sync_err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();

      // Owner fst mid-burst is forwarded as a plain beat and flagged.
      drive(1'b1, 1'b1, da(0), 1'b0, 1'b0, 32'h0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("sync_err_pre", sync_err, 1'b0);
      drive(1'b1, 1'b1, da(1), 1'b0, 1'b0, 32'h0, 1'b1);
      step(0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("sync_err_fst", sync_err, 1'b1);
      beats(0, 2, 49, 1'b0, 1'b0, 1'b0, 32'h0);

      // Asynchronous reset at beat 50 with results in flight.
      drive(1'b1, 1'b0, da(50), 1'b0, 1'b0, 32'h0, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_req0_rdy", req0_rdy, 1'b0);
      chk("arst_dp_vld", dp_vld, 1'b0);
      chk("arst_dp_data", dp_data, 32'h0);
      chk("arst_err0_vld", err0_vld, 1'b0);
      chk("arst_err0_data", err0_data, 32'h0);
      chk("arst_sync_err", sync_err, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_model();
      idle(4);

      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, db(0), 1'b1);
      step(1, 1'b0, 1'b1, 1'b1, 1'b0);
      beats(1, 1, FL - 1, 1'b0, 1'b0, 1'b0, 32'h0);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
